// File: rtl/secuenciador_rtc_pkg.sv
// secuenciador_rtc_pkg: shared definitions for the RTC transaction sequencer.
// This package holds the FSM state encoding, the fixed refresh transaction
// list, and a helper function that maps a list index to its RTC address.
package secuenciador_rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_COMMIT = 3'd4
  } estado_t;

  // The refresh sequence has seven transactions. Index 0 is the transfer
  // command write. Indexes 1..6 are the time-register reads.
  localparam int N_TRANS    = 7;
  localparam int N_LECTURAS = N_TRANS - 1;

  localparam logic [7:0] ADDR_CMD          = 8'hF0;
  localparam logic [7:0] CMD_TRANSFER_DATA = 8'h00;

  // Read addresses packed low-to-high: seg, min, hora, fecha, mes, anio.
  localparam logic [N_LECTURAS*8-1:0] ADDR_LECTURA = {
    8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  // Return the RTC address used by refresh list entry 'indice'.
  // Index 0 returns the command register address.
  function automatic logic [7:0] addr_de_indice(input logic [2:0] indice);
    logic [7:0] a;
    a = ADDR_CMD;
    for (int i = 1; i < N_TRANS; i++) begin
      if (indice == 3'(i)) a = ADDR_LECTURA[8*(i-1) +: 8];
    end
    return a;
  endfunction

endpackage

// File: rtl/secuenciador_rtc_contador.sv
// contador_refresco_rtc: free-running counter that runs 0..REFRESH_CYCLES-1
// and wraps. The tick output is high during the last count. The counter
// therefore wraps on the same clock edge that samples the tick.
module contador_refresco_rtc #(
  parameter int REFRESH_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count up and wrap at the end of the refresh period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: upstream controller for the RTC reader/writer stage.
// It periodically runs a command write followed by six time reads. It commits
// the six bytes to the time outputs together. It also arbitrates single user
// writes into the same transaction interface.
// Optional build macro SECUENCIADOR_RTC_TIMEOUT_EN adds a bounded wait for
// fin_lectura_escritura and the sticky error_timeout flag.
module secuenciador_rtc
  import secuenciador_rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 10000000,
  parameter int GAP_CYCLES     = 4
`ifdef SECUENCIADOR_RTC_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_escritura,
  input  logic [7:0] addr_escritura,
  input  logic [7:0] dato_escritura,
  output logic       ack_escritura,
  output logic       en_funcion,
  output logic       escribir_leer,
  output logic [7:0] addr_RAM,
  output logic [7:0] in_dato,
  input  logic       fin_lectura_escritura,
  input  logic [7:0] out_dato,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] fecha,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       actualizado,
  output logic       error_timeout
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       ULTIMO_INDICE = 3'(N_TRANS - 1);

  estado_t          state_reg, state_next;
  logic [2:0]       index_reg, index_next;
  logic             es_usuario_reg, es_usuario_next;
  logic             refresh_pend_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             ack_escritura_reg;
  logic             escribir_leer_reg;
  logic [7:0]       addr_reg;
  logic [7:0]       dato_reg;
  logic             tick;
  logic             vencido;
  logic             acepta_usuario;
  logic             acepta_refresco;
  logic             carga_campos;
  logic             carga_commit;
  logic             captura;
  logic [7:0]       tiempo [N_LECTURAS];

  contador_refresco_rtc #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_contador (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // A user request is held until it is acknowledged. Blocking it during the
  // ack cycle prevents the same request from being accepted twice.
  assign acepta_usuario  = (state_reg == S_IDLE) && req_escritura && !ack_escritura_reg;
  assign acepta_refresco = (state_reg == S_IDLE) && !acepta_usuario && refresh_pend_reg;
  assign carga_campos    = (state_next == S_ISSUE) && (state_reg != S_ISSUE);
  assign carga_commit    = (state_reg == S_GAP) && (state_next == S_COMMIT);
  assign captura         = (state_reg == S_WAIT) && fin_lectura_escritura && !es_usuario_reg;

  // State register, including the transaction index and the user/refresh owner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      index_reg      <= '0;
      es_usuario_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      es_usuario_reg <= es_usuario_next;
    end
  end

  // Next-state logic. A user write wins over a pending refresh.
  // Refresh sequences are never interrupted.
  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    es_usuario_next = es_usuario_reg;
    case (state_reg)
      S_IDLE: begin
        if (acepta_usuario) begin
          state_next      = S_ISSUE;
          es_usuario_next = 1'b1;
        end else if (acepta_refresco) begin
          state_next      = S_ISSUE;
          es_usuario_next = 1'b0;
          index_next      = '0;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (fin_lectura_escritura) begin
          state_next = S_GAP;
        end else if (vencido) begin
          state_next = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (es_usuario_reg) begin
            state_next = S_IDLE;
          end else if (index_reg < ULTIMO_INDICE) begin
            state_next = S_ISSUE;
            index_next = index_reg + 3'd1;
          end else begin
            state_next = S_COMMIT;
          end
        end
      end
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore outputs: the start pulse and the commit pulse.
  always_comb begin
    en_funcion  = (state_reg == S_ISSUE);
    actualizado = (state_reg == S_COMMIT);
  end

  // Latch the transaction fields on entry to S_ISSUE.
  // They stay stable until the next transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      escribir_leer_reg <= 1'b0;
      addr_reg          <= '0;
      dato_reg          <= '0;
    end else if (carga_campos) begin
      if (es_usuario_next) begin
        escribir_leer_reg <= 1'b1;
        addr_reg          <= addr_escritura;
        dato_reg          <= dato_escritura;
      end else begin
        escribir_leer_reg <= (index_next == 3'd0);
        addr_reg          <= addr_de_indice(index_next);
        dato_reg          <= CMD_TRANSFER_DATA;
      end
    end
  end

  // Count the idle gap after each completed transaction.
  always_ff @(posedge clk) begin
    if (!reset || state_reg != S_GAP) begin
      gap_cnt_reg <= '0;
    end else begin
      gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
    end
  end

  // Hold at most one pending refresh. A new tick always re-arms the flag,
  // even in the cycle where a user write is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_pend_reg <= 1'b0;
    end else if (tick) begin
      refresh_pend_reg <= 1'b1;
    end else if (acepta_refresco) begin
      refresh_pend_reg <= 1'b0;
    end
  end

  // Pulse the user acknowledge when a user write leaves the gap.
  // A user write that times out also acknowledges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_escritura_reg <= 1'b0;
    end else begin
      ack_escritura_reg <= es_usuario_reg &&
                           (((state_reg == S_GAP) && (gap_cnt_reg == GAP_LAST)) || vencido);
    end
  end

  // One shadow byte and one committed output byte per time register.
  // The committed bytes load on entry to S_COMMIT, so they are valid
  // together with the actualizado pulse.
  for (genvar gi = 0; gi < N_LECTURAS; gi++) begin : g_sombra
    logic [7:0] sombra_reg;
    logic [7:0] hora_reg;

    // Capture the read byte that belongs to this register.
    always_ff @(posedge clk) begin
      if (!reset) begin
        sombra_reg <= '0;
      end else if (captura && index_reg == 3'(gi + 1)) begin
        sombra_reg <= out_dato;
      end
    end

    // Publish the shadow only when the whole sequence has completed.
    always_ff @(posedge clk) begin
      if (!reset) begin
        hora_reg <= '0;
      end else if (carga_commit) begin
        hora_reg <= sombra_reg;
      end
    end

    assign tiempo[gi] = hora_reg;
  end

`ifdef SECUENCIADOR_RTC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] espera_cnt_reg;
  logic            error_timeout_reg;

  // Count the cycles spent in S_WAIT for the current transaction.
  always_ff @(posedge clk) begin
    if (!reset || state_reg != S_WAIT) begin
      espera_cnt_reg <= '0;
    end else begin
      espera_cnt_reg <= espera_cnt_reg + TO_W'(1);
    end
  end

  assign vencido = (state_reg == S_WAIT) && !fin_lectura_escritura &&
                   (espera_cnt_reg == TO_LAST);

  // Sticky timeout flag. It is set on abort and cleared by the next commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      error_timeout_reg <= 1'b0;
    end else if (vencido) begin
      error_timeout_reg <= 1'b1;
    end else if (carga_commit) begin
      error_timeout_reg <= 1'b0;
    end
  end

  assign error_timeout = error_timeout_reg;
`else
  assign vencido       = 1'b0;
  assign error_timeout = 1'b0;
`endif

  assign ack_escritura = ack_escritura_reg;
  assign escribir_leer = escribir_leer_reg;
  assign addr_RAM      = addr_reg;
  assign in_dato       = dato_reg;
  assign segundos      = tiempo[0];
  assign minutos       = tiempo[1];
  assign horas         = tiempo[2];
  assign fecha         = tiempo[3];
  assign mes           = tiempo[4];
  assign anio          = tiempo[5];

endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb_secuenciador_rtc: directed bench for secuenciador_rtc.
// A small RTC model answers each transaction 5 cycles after en_funcion.
// Expected transactions and commits are queued when stimulus is set up,
// and they are popped when the DUT produces them.
module tb_secuenciador_rtc;

  localparam int REFRESH = 100;
  localparam int GAP     = 4;
  localparam int LAT     = 5;
  localparam int TIMEOUT = 256;
  localparam logic [47:0] T_ESPERADO = 48'h11_12_13_14_15_16;

  typedef struct packed {
    logic       el;
    logic [7:0] addr;
    logic [7:0] dato;
  } tr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_escritura = 1'b0;
  logic [7:0] addr_escritura = 8'h00;
  logic [7:0] dato_escritura = 8'h00;
  logic       fin_lectura_escritura = 1'b0;
  logic [7:0] out_dato = 8'h00;
  logic       ack_escritura, en_funcion, escribir_leer, actualizado, error_timeout;
  logic [7:0] addr_RAM, in_dato, segundos, minutos, horas, fecha, mes, anio;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int tb_cnt = 0;
  int last_fin_cyc = 0;
  int exp_ack = 0;
  tr_t         exp_tr[$];
  logic [47:0] exp_commit[$];

  // RTC model state
  int         pend = 0;
  logic       pend_el = 1'b0;
  logic [7:0] pend_addr = 8'h00;
  logic       stale = 1'b0;
  logic       noanswer_en = 1'b0;
  logic [7:0] noanswer_addr = 8'h00;

  always #5 clk = ~clk;

  secuenciador_rtc #(
    .REFRESH_CYCLES(REFRESH),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_escritura        (req_escritura),
    .addr_escritura       (addr_escritura),
    .dato_escritura       (dato_escritura),
    .ack_escritura        (ack_escritura),
    .en_funcion           (en_funcion),
    .escribir_leer        (escribir_leer),
    .addr_RAM             (addr_RAM),
    .in_dato              (in_dato),
    .fin_lectura_escritura(fin_lectura_escritura),
    .out_dato             (out_dato),
    .segundos             (segundos),
    .minutos              (minutos),
    .horas                (horas),
    .fecha                (fecha),
    .mes                  (mes),
    .anio                 (anio),
    .actualizado          (actualizado),
    .error_timeout        (error_timeout)
  );

  // Cycle counter and reference refresh-period counter.
  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (!reset) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == REFRESH - 1) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tr_t mk(input logic el, input logic [7:0] a, input logic [7:0] d);
    tr_t t;
    t.el = el; t.addr = a; t.dato = d;
    return t;
  endfunction

  task automatic push_refresco();
    exp_tr.push_back(mk(1'b1, 8'hF0, 8'h00));
    for (int i = 1; i <= 6; i++) exp_tr.push_back(mk(1'b0, 8'h20 + 8'(i), 8'h00));
  endtask

  task automatic esperar_act(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (!actualizado && n < max);
    chk("espera_actualizado", actualizado, 1'b1);
  endtask

  task automatic esperar_ack(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ack_escritura && n < max);
    chk("espera_ack", ack_escritura, 1'b1);
  endtask

  task automatic esperar_en(input logic el, input logic [7:0] a, input int max);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(en_funcion && escribir_leer == el && addr_RAM == a) && n < max);
    chk("espera_en", {en_funcion, escribir_leer, addr_RAM}, {1'b1, el, a});
  endtask

  // RTC model: answer LAT cycles after en_funcion. Read data is 0x10 + addr[3:0].
  initial forever begin
    @(negedge clk);
    fin_lectura_escritura = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        fin_lectura_escritura = 1'b1;
        out_dato = pend_el ? 8'hA5 : (8'h10 + {4'h0, pend_addr[3:0]});
        last_fin_cyc = ncyc;
        if (!stale) chk("campos_estables", {escribir_leer, addr_RAM}, {pend_el, pend_addr});
      end
    end
    if (reset && en_funcion) begin
      if (noanswer_en && addr_RAM == noanswer_addr) begin
        noanswer_en = 1'b0;
        pend = 0;
      end else begin
        pend = LAT;
        pend_el = escribir_leer;
        pend_addr = addr_RAM;
        stale = 1'b0;
      end
    end
  end

  // Transaction scoreboard: every en_funcion must match the next expected entry.
  initial forever begin
    tr_t t;
    @(negedge clk);
    if (reset && en_funcion) begin
      chk("en_esperado", 64'(exp_tr.size() > 0), 1);
      if (exp_tr.size() > 0) begin
        t = exp_tr.pop_front();
        $display("tr: el=%0b addr=%02h dato=%02h (exp el=%0b addr=%02h)",
                 escribir_leer, addr_RAM, in_dato, t.el, t.addr);
        if (t.el) begin
          chk("tr_escritura", {escribir_leer, addr_RAM, in_dato}, {t.el, t.addr, t.dato});
        end else begin
          chk("tr_lectura", {escribir_leer, addr_RAM}, {t.el, t.addr});
          chk("lat_fin_en", 64'(ncyc - last_fin_cyc), GAP + 1);
        end
      end
    end
  end

  // Commit scoreboard
  initial forever begin
    logic [47:0] e;
    @(negedge clk);
    if (reset && actualizado) begin
      chk("act_esperado", 64'(exp_commit.size() > 0), 1);
      if (exp_commit.size() > 0) begin
        e = exp_commit.pop_front();
        $display("commit: %02h %02h %02h %02h %02h %02h", segundos, minutos, horas, fecha, mes, anio);
        chk("tiempo_commit", {segundos, minutos, horas, fecha, mes, anio}, e);
        chk("lat_fin_act", 64'(ncyc - last_fin_cyc), GAP + 1);
        chk("error_tras_commit", error_timeout, 1'b0);
      end
    end
  end

  // Acknowledge monitor
  initial forever begin
    @(negedge clk);
    if (reset && ack_escritura) begin
      $display("ack at cycle %0d", ncyc);
      chk("ack_esperado", 64'(exp_ack > 0), 1);
      if (exp_ack > 0) exp_ack--;
      chk("lat_fin_ack", 64'(ncyc - last_fin_cyc), GAP + 1);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    // Reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_control", {en_funcion, ack_escritura, actualizado, escribir_leer, error_timeout}, 0);
    chk("reset_campos", {addr_RAM, in_dato}, 0);
    chk("reset_tiempo", {segundos, minutos, horas, fecha, mes, anio}, 0);

    // First periodic refresh
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    reset = 1'b1;
    esperar_act(300);
    chk("tiempo_refresco1", {segundos, minutos, horas, fecha, mes, anio}, T_ESPERADO);

    // User write while idle
    @(negedge clk);
    exp_tr.push_back(mk(1'b1, 8'h23, 8'h12));
    exp_ack++;
    addr_escritura = 8'h23; dato_escritura = 8'h12; req_escritura = 1'b1;
    t0 = ncyc;
    esperar_en(1'b1, 8'h23, 10);
    chk("lat_req_en", 64'(ncyc - t0), 1);
    esperar_ack(40);
    req_escritura = 1'b0;

    // Request raised at the third read; served after the commit
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    exp_tr.push_back(mk(1'b1, 8'h25, 8'h99));
    exp_ack++;
    esperar_en(1'b0, 8'h23, 200);
    addr_escritura = 8'h25; dato_escritura = 8'h99; req_escritura = 1'b1;
    esperar_act(100);
    esperar_ack(60);
    req_escritura = 1'b0;

    // Refresh tick and request in the same cycle
    exp_tr.push_back(mk(1'b1, 8'h21, 8'h45));
    exp_ack++;
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    n = 0;
    while (tb_cnt != REFRESH - 1 && n < 3 * REFRESH) begin @(negedge clk); n++; end
    chk("alinear_tick", 64'(tb_cnt), REFRESH - 1);
    addr_escritura = 8'h21; dato_escritura = 8'h45; req_escritura = 1'b1;
    esperar_ack(40);
    req_escritura = 1'b0;
    esperar_act(150);

    // Reset in the middle of a read, followed by a stale fin
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    esperar_en(1'b0, 8'h22, 200);
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b1;
    exp_tr.delete();
    exp_commit.delete();
    repeat (2) @(negedge clk);
    chk("reset_medio_tiempo", {segundos, minutos, horas, fecha, mes, anio}, 0);
    chk("reset_medio_ctrl", {en_funcion, escribir_leer, addr_RAM, actualizado}, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("tras_fin_viejo_tiempo", {segundos, minutos, horas, fecha, mes, anio}, 0);
    chk("tras_fin_viejo_ctrl", {escribir_leer, addr_RAM}, 0);
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    esperar_act(250);
    chk("tiempo_tras_reset", {segundos, minutos, horas, fecha, mes, anio}, T_ESPERADO);

`ifdef SECUENCIADOR_RTC_TIMEOUT_EN
    // Read 0x24 never answered: abort, flag set, outputs unchanged
    exp_tr.push_back(mk(1'b1, 8'hF0, 8'h00));
    for (int i = 1; i <= 4; i++) exp_tr.push_back(mk(1'b0, 8'h20 + 8'(i), 8'h00));
    push_refresco();
    exp_commit.push_back(T_ESPERADO);
    noanswer_addr = 8'h24;
    noanswer_en = 1'b1;
    esperar_en(1'b0, 8'h24, 250);
    t0 = ncyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!error_timeout && n < TIMEOUT + 20);
    chk("error_timeout_set", error_timeout, 1'b1);
    chk("lat_timeout", 64'(ncyc - t0), TIMEOUT + 1);
    chk("tiempo_sin_cambio", {segundos, minutos, horas, fecha, mes, anio}, T_ESPERADO);
    esperar_act(300);
    chk("error_timeout_clr", error_timeout, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("cola_tr_vacia", 64'(exp_tr.size()), 0);
    chk("acks_pendientes", 64'(exp_ack), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
